eth_led_frame_sink: RTL and testbench
=====================================

Name: eth_led_frame_sink

Overview:
- Consumes decoded Ethernet frames (header + 8-bit AXI-Stream payload) and writes pixel data into an LED-matrix framebuffer write port.
- Filters frames by EtherType and destination MAC, then parses a 3-byte command preamble.
- Issues a buffer-swap pulse when a good frame requests it.
- Sits between the Ethernet RX header parser and the matrix scan/framebuffer logic, replacing the current always-ready payload discard.

Parameters:
- NUM_PIXELS, 2048, framebuffer depth in pixels (e.g. 64x32 matrix).
- ADDR_WIDTH, $clog2(NUM_PIXELS), framebuffer address width.
- PIXEL_BYTES, 3, payload bytes per pixel (1..4), MSB first.
- ETH_TYPE, 16'h88B5, accepted EtherType.
- LOCAL_MAC, 48'h02_00_00_00_00_01, accepted unicast destination; broadcast FF:FF:FF:FF:FF:FF is also accepted.
- CNT_WIDTH, 16, width of status counters.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- s_eth_hdr_valid  in  1  header valid
- s_eth_hdr_ready  out  1  header ready
- s_eth_dest_mac  in  48  destination MAC
- s_eth_type  in  16  EtherType
- s_eth_payload_axis_tdata  in  8  payload byte
- s_eth_payload_axis_tvalid  in  1  payload valid
- s_eth_payload_axis_tready  out  1  payload ready
- s_eth_payload_axis_tlast  in  1  last payload byte
- s_eth_payload_axis_tuser  in  1  bad-frame flag, meaningful with tlast
- fb_wr_en  out  1  framebuffer write strobe
- fb_wr_addr  out  ADDR_WIDTH  pixel address
- fb_wr_data  out  8*PIXEL_BYTES  pixel value
- fb_swap  out  1  one-cycle swap request
- frame_done  out  1  one-cycle pulse: good frame finished
- frame_err  out  1  one-cycle pulse: frame rejected or errored
- frames_ok  out  CNT_WIDTH  good-frame count, saturating
- frames_bad  out  CNT_WIDTH  errored-frame count, saturating; filter misses are not counted

Behaviour:
- Reset: every output is 0. State = IDLE. Counters clear. Reset asserted mid-frame abandons the frame with no pulses; the remaining bytes of that frame are then dropped through the normal path once a header arrives.
- States: IDLE, PRE, PIX, DROP.
- IDLE:
  - s_eth_hdr_ready=1, payload tready=0.
  - On a header handshake: match = (type==ETH_TYPE) && (dest==LOCAL_MAC || dest==broadcast).
  - Match -> PRE; no match -> DROP.
- PRE (tready=1): accepts 3 bytes.
  - byte0 bit0 = swap_req (other bits ignored).
  - byte1:byte2 = start pixel index, big-endian.
  - After byte2 -> PIX with addr=index, byte count cleared.
  - Index >= NUM_PIXELS -> DROP, counted as error at tlast.
  - tlast inside PRE -> frame_err, frames_bad++, -> IDLE.
- PIX (tready=1):
  - Bytes shift into the pixel register MSB first.
  - On the PIXEL_BYTES-th byte: the next cycle drives fb_wr_en=1 with the current addr/data (latency 1 cycle from the accepting edge); addr increments.
  - If addr would reach NUM_PIXELS, later bytes are discarded without writes; this is not an error.
- End of frame in PIX (tlast accepted):
  - Partial pixel outstanding or tuser=1 -> frame_err, frames_bad++, no swap.
  - Otherwise -> frame_done, frames_ok++, and fb_swap=1 if swap_req.
  - A final complete pixel writes in the same cycle as the pulses.
  - -> IDLE.
  - Pixels already written by an errored frame remain written; the swap is withheld so they are never displayed.
- DROP (tready=1): consume until tlast, -> IDLE. frame_err pulses only if the drop was caused by an out-of-range index.
- Backpressure: tready is never deasserted mid-frame. The block accepts one byte per cycle whenever tvalid is high.
- Counters saturate at all-ones.
- Address arithmetic is ADDR_WIDTH+1 bits wide to detect the end without wrap-around.

Test Plan:
- Good frame, type 88B5, dest LOCAL_MAC, payload 01 00 05 then 6 bytes AA BB CC 11 22 33 -> writes addr5=AABBCC, addr6=112233; fb_swap=1 and frame_done=1 once; frames_ok=1.
- Same frame with EtherType 0800 -> no writes, no pulses, all bytes consumed, counters unchanged; a following good frame is accepted normally.
- Payload 00 07 FE then 3 pixels with NUM_PIXELS=2048 -> only addr 2046 and 2047 written; frame_done=1, fb_swap=0.
- Payload 01 00 00 then 4 bytes with the last byte carrying tlast -> addr0 written, fourth byte discarded; frame_err=1, fb_swap=0, frames_bad=1.
- Good frame with tuser=1 on tlast -> pixels written, frame_err=1, no swap. Then broadcast dest with a 2-byte payload -> frame_err from PRE.
- rst asserted while in PIX -> outputs 0 asynchronously; after release, the next header/frame is processed from IDLE correctly.

Source files
------------

// File: rtl/eth_led_frame_sink.sv
// Ethernet payload sink for an LED matrix: filters frames by EtherType/MAC, parses a
// 3-byte preamble (swap flag + start index) and streams pixels into a framebuffer port.
module eth_led_frame_sink #(
    parameter int          NUM_PIXELS  = 2048,
    parameter int          ADDR_WIDTH  = $clog2(NUM_PIXELS),
    parameter int          PIXEL_BYTES = 3,
    parameter logic [15:0] ETH_TYPE    = 16'h88B5,
    parameter logic [47:0] LOCAL_MAC   = 48'h02_00_00_00_00_01,
    parameter int          CNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_eth_hdr_valid,
    output logic                     s_eth_hdr_ready,
    input  logic [47:0]              s_eth_dest_mac,
    input  logic [15:0]              s_eth_type,
    input  logic [7:0]               s_eth_payload_axis_tdata,
    input  logic                     s_eth_payload_axis_tvalid,
    output logic                     s_eth_payload_axis_tready,
    input  logic                     s_eth_payload_axis_tlast,
    input  logic                     s_eth_payload_axis_tuser,
    output logic                     fb_wr_en,
    output logic [ADDR_WIDTH-1:0]    fb_wr_addr,
    output logic [8*PIXEL_BYTES-1:0] fb_wr_data,
    output logic                     fb_swap,
    output logic                     frame_done,
    output logic                     frame_err,
    output logic [CNT_WIDTH-1:0]     frames_ok,
    output logic [CNT_WIDTH-1:0]     frames_bad
);

    localparam int                  PIX_W     = 8 * PIXEL_BYTES;
    localparam logic [47:0]         BCAST_MAC = 48'hFFFF_FFFF_FFFF;
    localparam logic [ADDR_WIDTH:0] ADDR_END  = (ADDR_WIDTH + 1)'(NUM_PIXELS);
    localparam logic [1:0]          LAST_BYTE = 2'(PIXEL_BYTES - 1);

    typedef enum logic [1:0] {IDLE, PRE, PIX, DROP} state_t;

    state_t                state;
    logic [1:0]            pre_cnt;
    logic [1:0]            byte_cnt;
    logic                  swap_req;
    logic                  range_err;
    logic [7:0]            idx_hi;
    logic [ADDR_WIDTH:0]   addr;
    logic [PIX_W-1:0]      pix;

    logic                  hdr_match;
    logic                  beat;
    logic [15:0]           idx;
    logic [PIX_W-1:0]      pix_next;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign hdr_match = (s_eth_type == ETH_TYPE) &&
                       ((s_eth_dest_mac == LOCAL_MAC) || (s_eth_dest_mac == BCAST_MAC));
    assign beat      = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready;
    assign idx       = {idx_hi, s_eth_payload_axis_tdata};
    // Newest byte enters at the LSB end, so the first byte of a pixel ends up as its MSB.
    assign pix_next  = PIX_W'({pix, s_eth_payload_axis_tdata});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                     <= IDLE;
            s_eth_hdr_ready           <= 1'b0;
            s_eth_payload_axis_tready <= 1'b0;
            fb_wr_en                  <= 1'b0;
            fb_wr_addr                <= '0;
            fb_wr_data                <= '0;
            fb_swap                   <= 1'b0;
            frame_done                <= 1'b0;
            frame_err                 <= 1'b0;
            frames_ok                 <= '0;
            frames_bad                <= '0;
            pre_cnt                   <= '0;
            byte_cnt                  <= '0;
            swap_req                  <= 1'b0;
            range_err                 <= 1'b0;
            idx_hi                    <= '0;
            addr                      <= '0;
            pix                       <= '0;
        end else begin
            fb_wr_en   <= 1'b0;
            fb_swap    <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;

            case (state)
                IDLE: begin
                    s_eth_hdr_ready <= 1'b1;
                    if (s_eth_hdr_valid && s_eth_hdr_ready) begin
                        s_eth_hdr_ready           <= 1'b0;
                        s_eth_payload_axis_tready <= 1'b1;
                        pre_cnt                   <= '0;
                        range_err                 <= 1'b0;
                        swap_req                  <= 1'b0;
                        state                     <= hdr_match ? PRE : DROP;
                    end
                end

                PRE: begin
                    if (beat) begin
                        pre_cnt <= pre_cnt + 2'd1;
                        case (pre_cnt)
                            2'd0:    swap_req <= s_eth_payload_axis_tdata[0];
                            2'd1:    idx_hi   <= s_eth_payload_axis_tdata;
                            default: begin
                                addr     <= (ADDR_WIDTH + 1)'(idx);
                                byte_cnt <= '0;
                            end
                        endcase
                        if (s_eth_payload_axis_tlast) begin
                            frame_err                 <= 1'b1;
                            frames_bad                <= sat_inc(frames_bad);
                            s_eth_payload_axis_tready <= 1'b0;
                            s_eth_hdr_ready           <= 1'b1;
                            state                     <= IDLE;
                        end else if (pre_cnt == 2'd2) begin
                            if ({16'd0, idx} >= 32'(NUM_PIXELS)) begin
                                range_err <= 1'b1;
                                state     <= DROP;
                            end else begin
                                state <= PIX;
                            end
                        end
                    end
                end

                PIX: begin
                    if (beat) begin
                        pix <= pix_next;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            // Pixels past the end of the buffer are silently dropped.
                            if (addr < ADDR_END) begin
                                fb_wr_en   <= 1'b1;
                                fb_wr_addr <= addr[ADDR_WIDTH-1:0];
                                fb_wr_data <= pix_next;
                                addr       <= addr + (ADDR_WIDTH + 1)'(1);
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                        if (s_eth_payload_axis_tlast) begin
                            if ((byte_cnt != LAST_BYTE) || s_eth_payload_axis_tuser) begin
                                frame_err  <= 1'b1;
                                frames_bad <= sat_inc(frames_bad);
                            end else begin
                                frame_done <= 1'b1;
                                frames_ok  <= sat_inc(frames_ok);
                                fb_swap    <= swap_req;
                            end
                            s_eth_payload_axis_tready <= 1'b0;
                            s_eth_hdr_ready           <= 1'b1;
                            state                     <= IDLE;
                        end
                    end
                end

                DROP: begin
                    if (beat && s_eth_payload_axis_tlast) begin
                        // Filter misses are dropped quietly; only a bad start index is an error.
                        if (range_err) begin
                            frame_err  <= 1'b1;
                            frames_bad <= sat_inc(frames_bad);
                        end
                        s_eth_payload_axis_tready <= 1'b0;
                        s_eth_hdr_ready           <= 1'b1;
                        state                     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_led_frame_sink.sv
// Directed bench for eth_led_frame_sink: a frame-level model predicts writes, pulses and
// counters; one negedge process compares every write and pulse against it.
module tb_eth_led_frame_sink;

    localparam int          NUM   = 2048;
    localparam int          CW    = 3;
    localparam logic [15:0] ETH   = 16'h88B5;
    localparam logic [47:0] LMAC  = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BMAC  = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] OMAC  = 48'h02_00_00_00_00_99;
    localparam int          SATV  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_eth_hdr_valid = 1'b0;
    logic          s_eth_hdr_ready;
    logic [47:0]   s_eth_dest_mac = '0;
    logic [15:0]   s_eth_type = '0;
    logic [7:0]    tdata = '0;
    logic          tvalid = 1'b0;
    logic          tready;
    logic          tlast = 1'b0;
    logic          tuser = 1'b0;
    logic          fb_wr_en;
    logic [10:0]   fb_wr_addr;
    logic [23:0]   fb_wr_data;
    logic          fb_swap;
    logic          frame_done;
    logic          frame_err;
    logic [CW-1:0] frames_ok;
    logic [CW-1:0] frames_bad;

    eth_led_frame_sink #(.NUM_PIXELS(NUM), .CNT_WIDTH(CW)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .s_eth_hdr_valid           (s_eth_hdr_valid),
        .s_eth_hdr_ready           (s_eth_hdr_ready),
        .s_eth_dest_mac            (s_eth_dest_mac),
        .s_eth_type                (s_eth_type),
        .s_eth_payload_axis_tdata  (tdata),
        .s_eth_payload_axis_tvalid (tvalid),
        .s_eth_payload_axis_tready (tready),
        .s_eth_payload_axis_tlast  (tlast),
        .s_eth_payload_axis_tuser  (tuser),
        .fb_wr_en                  (fb_wr_en),
        .fb_wr_addr                (fb_wr_addr),
        .fb_wr_data                (fb_wr_data),
        .fb_swap                   (fb_swap),
        .frame_done                (frame_done),
        .frame_err                 (frame_err),
        .frames_ok                 (frames_ok),
        .frames_bad                (frames_bad)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [10:0] a; logic [23:0] d;} wr_t;
    typedef struct packed {logic done; logic err; logic swap;} ev_t;

    logic [7:0]  pl[$];
    wr_t         exp_wr[$];
    ev_t         exp_ev[$];
    int          m_ok = 0;
    int          m_bad = 0;
    int          vectors = 0;
    int          errors = 0;
    logic [10:0] last_addr = '0;
    logic [23:0] last_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic int sat(input int v);
        return (v < SATV) ? v + 1 : SATV;
    endfunction

    // Predict a whole frame from its payload bytes in pl.
    task automatic model_frame(input logic [47:0] dest, input logic [15:0] typ, input logic usr);
        int n, idx, np, a;
        logic e;
        n = pl.size();
        if (!(typ == ETH && (dest == LMAC || dest == BMAC))) return;
        if (n <= 3) begin
            exp_ev.push_back('{done: 1'b0, err: 1'b1, swap: 1'b0});
            m_bad = sat(m_bad);
            return;
        end
        idx = {16'd0, pl[1], pl[2]};
        if (idx >= NUM) begin
            exp_ev.push_back('{done: 1'b0, err: 1'b1, swap: 1'b0});
            m_bad = sat(m_bad);
            return;
        end
        np = n - 3;
        for (int k = 0; k < np / 3; k++) begin
            a = idx + k;
            if (a < NUM)
                exp_wr.push_back('{a: 11'(a), d: {pl[3 + 3*k], pl[4 + 3*k], pl[5 + 3*k]}});
        end
        e = (np % 3 != 0) || usr;
        exp_ev.push_back('{done: !e, err: e, swap: !e && pl[0][0]});
        if (e) m_bad = sat(m_bad);
        else   m_ok  = sat(m_ok);
    endtask

    // Drives header then payload from pl; abort_at >= 0 stops before that byte without tlast.
    task automatic send_frame(input logic [47:0] dest, input logic [15:0] typ, input logic usr,
                              input int abort_at, input bit gaps);
        int w;
        @(negedge clk);
        s_eth_dest_mac  = dest;
        s_eth_type      = typ;
        s_eth_hdr_valid = 1'b1;
        w = 0;
        while (!s_eth_hdr_ready && w < 50) begin @(negedge clk); w++; end
        if (w >= 50) begin
            fail_now("hdr_ready_wait");
            s_eth_hdr_valid = 1'b0;
            return;
        end
        @(negedge clk);
        s_eth_hdr_valid = 1'b0;
        for (int i = 0; i < pl.size(); i++) begin
            if (i == abort_at) begin
                tvalid = 1'b0;
                return;
            end
            if (gaps && (i % 2 == 1)) begin
                tvalid = 1'b0;
                @(negedge clk);
            end
            tdata  = pl[i];
            tvalid = 1'b1;
            tlast  = (i == pl.size() - 1);
            tuser  = (i == pl.size() - 1) ? usr : 1'b0;
            w = 0;
            while (!tready && w < 50) begin @(negedge clk); w++; end
            if (w >= 50) begin
                fail_now("tready_wait");
                tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
                return;
            end
            @(negedge clk);
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        tuser  = 1'b0;
    endtask

    task automatic end_check(input string tag);
        repeat (3) @(negedge clk);
        chk({tag, "_writes_left"}, 64'(exp_wr.size()), 64'd0);
        chk({tag, "_pulses_left"}, 64'(exp_ev.size()), 64'd0);
        chk({tag, "_frames_ok"}, 64'(frames_ok), 64'(m_ok));
        chk({tag, "_frames_bad"}, 64'(frames_bad), 64'(m_bad));
    endtask

    task automatic run(input string tag, input logic [47:0] dest, input logic [15:0] typ,
                       input logic usr, input bit gaps);
        model_frame(dest, typ, usr);
        send_frame(dest, typ, usr, -1, gaps);
        end_check(tag);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (fb_wr_en) begin
                if (exp_wr.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL unexpected_write: addr %0d data %0h, none required", fb_wr_addr, fb_wr_data);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", 64'(fb_wr_addr), 64'(e.a));
                    chk("wr_data", 64'(fb_wr_data), 64'(e.d));
                end
                last_addr = fb_wr_addr;
                last_data = fb_wr_data;
            end
            if (frame_done || frame_err || fb_swap) begin
                if (exp_ev.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL unexpected_pulse: done %b err %b swap %b, none required", frame_done, frame_err, fb_swap);
                end else begin
                    ev_t v;
                    v = exp_ev.pop_front();
                    chk("frame_done", 64'(frame_done), 64'(v.done));
                    chk("frame_err", 64'(frame_err), 64'(v.err));
                    chk("fb_swap", 64'(fb_swap), 64'(v.swap));
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({s_eth_hdr_ready, tready, fb_wr_en, fb_wr_addr, fb_wr_data,
                                   fb_swap, frame_done, frame_err, frames_ok, frames_bad}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("hdr_ready_after_reset", 64'(s_eth_hdr_ready), 64'd1);

        pl = '{8'h01, 8'h00, 8'h05, 8'hAA, 8'hBB, 8'hCC, 8'h11, 8'h22, 8'h33};
        run("good1", LMAC, ETH, 1'b0, 1'b0);
        chk("lit_good1_ok", 64'(frames_ok), 64'd1);
        chk("lit_good1_addr", 64'(last_addr), 64'd6);
        chk("lit_good1_data", 64'(last_data), 64'h112233);

        run("type0800", LMAC, 16'h0800, 1'b0, 1'b0);
        chk("lit_type_ok", 64'(frames_ok), 64'd1);
        chk("lit_type_bad", 64'(frames_bad), 64'd0);

        pl = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03};
        run("good_gaps", LMAC, ETH, 1'b0, 1'b1);
        chk("lit_gaps_data", 64'(last_data), 64'h010203);

        pl = '{8'h00, 8'h07, 8'hFE, 8'h40, 8'h41, 8'h42, 8'h50, 8'h51, 8'h52, 8'h60, 8'h61, 8'h62};
        run("end_clip", LMAC, ETH, 1'b0, 1'b0);
        chk("lit_clip_addr", 64'(last_addr), 64'd2047);
        chk("lit_clip_data", 64'(last_data), 64'h505152);

        pl = '{8'h01, 8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        run("partial", LMAC, ETH, 1'b0, 1'b0);
        chk("lit_partial_bad", 64'(frames_bad), 64'd1);
        chk("lit_partial_addr", 64'(last_addr), 64'd0);
        chk("lit_partial_data", 64'(last_data), 64'hA1A2A3);

        pl = '{8'h01, 8'h00, 8'h10, 8'h77, 8'h88, 8'h99};
        run("tuser", LMAC, ETH, 1'b1, 1'b0);

        pl = '{8'h01, 8'h00};
        run("bcast_short", BMAC, ETH, 1'b0, 1'b0);

        pl = '{8'h01, 8'h08, 8'h00, 8'h01, 8'h02, 8'h03};
        run("range", LMAC, ETH, 1'b0, 1'b0);
        chk("lit_range_bad", 64'(frames_bad), 64'd4);

        pl = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03};
        run("other_mac", OMAC, ETH, 1'b0, 1'b0);

        pl = '{8'h00, 8'h00};
        for (int i = 0; i < 6; i++) run("sat", LMAC, ETH, 1'b0, 1'b0);
        chk("lit_sat_bad", 64'(frames_bad), 64'(SATV));

        pl = '{8'h01, 8'h00, 8'h0A, 8'h11, 8'h22, 8'h33};
        send_frame(LMAC, ETH, 1'b0, 5, 1'b0);
        chk("tready_in_pix", 64'(tready), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outputs", 64'({s_eth_hdr_ready, tready, fb_wr_en, fb_wr_addr, fb_wr_data,
                                         fb_swap, frame_done, frame_err, frames_ok, frames_bad}), 64'd0);
        m_ok = 0;
        m_bad = 0;
        exp_wr.delete();
        exp_ev.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        pl = '{8'h01, 8'h00, 8'h20, 8'hDE, 8'hAD, 8'hBE};
        run("after_reset", BMAC, ETH, 1'b0, 1'b0);
        chk("lit_after_reset_ok", 64'(frames_ok), 64'd1);
        chk("lit_after_reset_addr", 64'(last_addr), 64'd32);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
